// File: rtl/vram_slot_arbiter.sv
// rtl/vram_slot_arbiter.sv - LSPC VRAM port arbiter between video fetch and 68k register access
module vram_slot_arbiter #(
  parameter int SLOT_BITS   = 2,
  parameter int CPU_SLOT_ID = 3,
  parameter int ACCESS_CYC  = 8,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        CLK_24MB,
  input  logic        nRESETP,
  input  logic        Q53_CO,
  input  logic [8:0]  PIXELC,
  input  logic        VBLANK,
  input  logic        WR_ADDR,
  input  logic        WR_MOD,
  input  logic        WR_DATA,
  input  logic [15:0] DIN,
  output logic [15:0] RDATA,
  output logic [15:0] MOD,
  output logic        BUSY,
  output logic        OVERRUN,
  input  logic [15:0] VID_ADDR,
  output logic [15:0] VRAM_ADDR,
  output logic [15:0] VRAM_DOUT,
  output logic        VRAM_WE,
  input  logic [15:0] VRAM_DIN,
  output logic        CPU_SLOT
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0]    K_LAST    = 4'(ACCESS_CYC - 1);
  localparam logic [3:0]    K_WE_LAST = 4'(ACCESS_CYC - 2);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

  state_e        state_q;
  logic [3:0]    k_q;
  logic          cpu_slot_q, we_q, op_write_q;
  logic [15:0]   op_addr_q, vram_dout_q, rdata_q;
  logic [15:0]   addr_q, addr_d, mod_q, mod_d;
  logic          overrun_q, overrun_d, pf_q, pf_d;
  logic [15:0]   fifo_addr_q [FIFO_DEPTH];
  logic [15:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          full, eligible, pop, push, have_write, start;
  logic [15:0]   head_addr, head_data;
  logic          unused_pixelc;

  assign unused_pixelc = ^PIXELC;

  assign full     = (count_q == DEPTH_C);
  assign eligible = VBLANK | (PIXELC[2 +: SLOT_BITS] == SLOT_BITS'(CPU_SLOT_ID));
  assign pop      = (state_q == ACCESS) && (k_q == K_LAST) && op_write_q;

  // Register strobes, queue push decision and slot-start decision
  always_comb begin
    addr_d     = addr_q;
    mod_d      = mod_q;
    overrun_d  = overrun_q;
    pf_d       = pf_q;
    push       = 1'b0;
    if (WR_MOD) mod_d = DIN;
    if (WR_ADDR) begin
      // A data strobe colliding with an address strobe is lost and flagged
      addr_d    = DIN;
      overrun_d = WR_DATA;
      pf_d      = 1'b1;
    end else if (WR_DATA) begin
      if (full) begin
        overrun_d = 1'b1;
      end else begin
        push   = 1'b1;
        addr_d = addr_q + mod_q;
      end
    end
    if (pop) pf_d = 1'b1;
    have_write = (count_q != '0) | push;
    start      = (state_q == IDLE) && Q53_CO && eligible && (have_write || pf_d);
    // A prefetch consumes the pending flag at launch so a WR_ADDR during it re-arms
    if (start && !have_write) pf_d = 1'b0;
    head_addr = (count_q != '0) ? fifo_addr_q[rd_ptr_q] : addr_q;
    head_data = (count_q != '0) ? fifo_data_q[rd_ptr_q] : DIN;
  end

  // CPU-visible registers and the write queue
  always_ff @(posedge CLK_24MB or negedge nRESETP) begin
    if (!nRESETP) begin
      addr_q    <= '0;
      mod_q     <= '0;
      overrun_q <= 1'b0;
      pf_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      mod_q     <= mod_d;
      overrun_q <= overrun_d;
      pf_q      <= pf_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= addr_q;
        fifo_data_q[wr_ptr_q] <= DIN;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Access FSM: owns the port for ACCESS_CYC clocks, WE framed by one setup and one hold clock
  always_ff @(posedge CLK_24MB or negedge nRESETP) begin
    if (!nRESETP) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cpu_slot_q  <= 1'b0;
      we_q        <= 1'b0;
      op_write_q  <= 1'b0;
      op_addr_q   <= '0;
      vram_dout_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCESS;
            k_q        <= '0;
            cpu_slot_q <= 1'b1;
            we_q       <= 1'b0;
            op_write_q <= have_write;
            op_addr_q  <= have_write ? head_addr : addr_d;
            if (have_write) vram_dout_q <= head_data;
          end
        end
        ACCESS: begin
          if (k_q == K_LAST) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cpu_slot_q <= 1'b0;
            we_q       <= 1'b0;
            if (!op_write_q) rdata_q <= VRAM_DIN;
          end else begin
            k_q  <= k_q + 1'b1;
            we_q <= op_write_q && ((k_q + 4'd1) <= K_WE_LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign VRAM_ADDR = cpu_slot_q ? op_addr_q : VID_ADDR;
  assign VRAM_DOUT = vram_dout_q;
  assign VRAM_WE   = we_q;
  assign CPU_SLOT  = cpu_slot_q;
  assign RDATA     = rdata_q;
  assign MOD       = mod_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (count_q != '0) | pf_q | (state_q == ACCESS);

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb/tb_vram_slot_arbiter.sv - self-checking bench for vram_slot_arbiter
module tb_vram_slot_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Q53_CO = 1'b0;
  logic [8:0]  PIXELC = '0;
  logic        VBLANK = 1'b0, WR_ADDR = 1'b0, WR_MOD = 1'b0, WR_DATA = 1'b0;
  logic [15:0] DIN = '0, VID_ADDR = '0;
  logic [15:0] RDATA, MOD, VRAM_ADDR, VRAM_DOUT, VRAM_DIN;
  logic        BUSY, OVERRUN, VRAM_WE, CPU_SLOT;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int slot = 0;
  int we_cnt = 0;
  int rises[$];
  bit prev_cpu = 1'b0;

  always #5 clk = ~clk;

  vram_slot_arbiter dut (
    .CLK_24MB(clk), .nRESETP(rst_n), .Q53_CO(Q53_CO), .PIXELC(PIXELC), .VBLANK(VBLANK),
    .WR_ADDR(WR_ADDR), .WR_MOD(WR_MOD), .WR_DATA(WR_DATA), .DIN(DIN),
    .RDATA(RDATA), .MOD(MOD), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .VID_ADDR(VID_ADDR), .VRAM_ADDR(VRAM_ADDR), .VRAM_DOUT(VRAM_DOUT),
    .VRAM_WE(VRAM_WE), .VRAM_DIN(VRAM_DIN), .CPU_SLOT(CPU_SLOT)
  );

  assign VRAM_DIN = mem[VRAM_ADDR];
  always @(posedge clk) if (VRAM_WE) mem[VRAM_ADDR] <= VRAM_DOUT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slot timing: one Q53_CO every 16 clocks, PIXELC advances one slot (4 pixels) per strobe
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    Q53_CO = (cyc % 16 == 0);
    if (Q53_CO) begin
      slot++;
      PIXELC = 9'(slot * 4);
    end
    VID_ADDR = 16'(cyc * 7 + 256);
  end

  // Reference model: registers, a queue of {addr,data} entries and an access countdown
  logic [15:0] m_addr, m_mod, m_rdata, m_dout, m_opaddr;
  bit          m_over, m_pf, m_act, m_opw;
  int          m_k;
  logic [31:0] m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = 0; m_mod = 0; m_rdata = 0; m_dout = 0; m_opaddr = 0;
      m_over = 0; m_pf = 0; m_act = 0; m_opw = 0; m_k = 0;
      m_q.delete();
    end else begin
      bit elig;
      logic [15:0] old_mod;
      elig = VBLANK || ((PIXELC / 4) % 4 == 3);
      old_mod = m_mod;
      if (WR_ADDR) begin
        m_addr = DIN;
        m_pf = 1;
        m_over = WR_DATA;
      end else if (WR_DATA) begin
        if (m_q.size() >= 2) m_over = 1;
        else begin
          m_q.push_back({m_addr, DIN});
          m_addr = m_addr + old_mod;
        end
      end
      if (WR_MOD) m_mod = DIN;
      if (m_act) begin
        if (m_k == 7) begin
          m_act = 0;
          if (m_opw) begin
            void'(m_q.pop_front());
            m_pf = 1;
          end else m_rdata = mem[m_opaddr];
        end else m_k++;
      end else if (Q53_CO && elig && (m_q.size() > 0 || m_pf)) begin
        m_act = 1;
        m_k = 0;
        if (m_q.size() > 0) begin
          m_opw = 1;
          m_opaddr = m_q[0][31:16];
          m_dout = m_q[0][15:0];
        end else begin
          m_opw = 0;
          m_opaddr = m_addr;
          m_pf = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("VRAM_WE", VRAM_WE, m_act && m_opw && m_k >= 1 && m_k <= 6);
      chk("CPU_SLOT", CPU_SLOT, m_act);
      chk("VRAM_ADDR", VRAM_ADDR, m_act ? m_opaddr : VID_ADDR);
      chk("VRAM_DOUT", VRAM_DOUT, m_dout);
      chk("RDATA", RDATA, m_rdata);
      chk("MOD", MOD, m_mod);
      chk("OVERRUN", OVERRUN, m_over);
      chk("BUSY", BUSY, (m_q.size() > 0) || m_pf || m_act);
      if (VRAM_WE) we_cnt++;
      if (CPU_SLOT && !prev_cpu) rises.push_back(cyc);
      prev_cpu = CPU_SLOT;
    end
  end

  task automatic strobe(input bit a, input bit m, input bit d, input logic [15:0] v);
    WR_ADDR = a; WR_MOD = m; WR_DATA = d; DIN = v;
    @(posedge clk);
    #1;
    WR_ADDR = 0; WR_MOD = 0; WR_DATA = 0;
  endtask

  task automatic wait_phase(input int p);
    bit found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(posedge clk);
      found = Q53_CO && (p < 0 || PIXELC[3:2] == 2'(p));
    end
    #1;
    chk("wait_phase", found, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk);
      #1;
      done = !BUSY;
    end
    chk("wait_idle", done, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_RDATA", RDATA, 0);
    chk("rst_MOD", MOD, 0);
    chk("rst_BUSY", BUSY, 0);
    chk("rst_OVERRUN", OVERRUN, 0);
    chk("rst_WE", VRAM_WE, 0);
    chk("rst_CPU_SLOT", CPU_SLOT, 0);
    rst_n = 1;

    // 1: display mode, write queued at phase 1, served at next phase 3, prefetch one slot-round later
    VBLANK = 0;
    wait_phase(1);
    rises.delete();
    we_cnt = 0;
    strobe(1, 0, 0, 16'h7000);
    strobe(0, 0, 1, 16'hBEEF);
    wait_idle();
    chk("t1_we_cycles", we_cnt, 6);
    chk("t1_mem7000", mem[16'h7000], 16'hBEEF);
    chk("t1_rdata", RDATA, 16'hBEEF);
    chk("t1_accesses", rises.size(), 2);
    if (rises.size() >= 2) chk("t1_prefetch_gap", rises[1] - rises[0], 64);

    // 2: modulo wrap
    VBLANK = 1;
    mem[16'h0030] <= 16'h3030;
    strobe(0, 1, 0, 16'h0020);
    strobe(1, 0, 0, 16'hFFF0);
    strobe(0, 0, 1, 16'h1111);
    strobe(0, 0, 1, 16'h2222);
    wait_idle();
    chk("t2_memFFF0", mem[16'hFFF0], 16'h1111);
    chk("t2_mem0010", mem[16'h0010], 16'h2222);
    chk("t2_rdata_at_0030", RDATA, 16'h3030);

    // 3: queue overflow, WR_ADDR clears OVERRUN
    VBLANK = 0;
    wait_phase(0);
    strobe(1, 0, 0, 16'h2000);
    strobe(0, 0, 1, 16'hA1A1);
    strobe(0, 0, 1, 16'hA2A2);
    strobe(0, 0, 1, 16'hA3A3);
    chk("t3_overrun_set", OVERRUN, 1);
    strobe(1, 0, 0, 16'h2100);
    chk("t3_overrun_clr", OVERRUN, 0);
    wait_idle();
    chk("t3_mem2000", mem[16'h2000], 16'hA1A1);
    chk("t3_mem2020", mem[16'h2020], 16'hA2A2);
    chk("t3_mem2040", mem[16'h2040], 16'h0000);

    // 4: vertical blank, consecutive slots
    VBLANK = 1;
    mem[16'h4040] <= 16'h4444;
    wait_phase(-1);
    strobe(1, 0, 0, 16'h4000);
    strobe(0, 0, 1, 16'hC1C1);
    strobe(0, 0, 1, 16'hC2C2);
    rises.delete();
    wait_idle();
    chk("t4_accesses", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("t4_gap1", rises[1] - rises[0], 16);
      chk("t4_gap2", rises[2] - rises[1], 16);
    end
    chk("t4_mem4000", mem[16'h4000], 16'hC1C1);
    chk("t4_mem4020", mem[16'h4020], 16'hC2C2);
    chk("t4_rdata", RDATA, 16'h4444);

    // 5: reset mid-write
    wait_phase(-1);
    strobe(1, 0, 0, 16'h5000);
    strobe(0, 0, 1, 16'hD5D5);
    found = 0;
    for (n = 0; n < 100 && !found; n++) begin
      @(posedge clk);
      #1;
      found = VRAM_WE;
    end
    chk("t5_we_seen", found, 1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("t5_we_drop", VRAM_WE, 0);
    chk("t5_cpu_slot", CPU_SLOT, 0);
    chk("t5_busy", BUSY, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (40) @(posedge clk);
    #1;
    chk("t5_busy_after", BUSY, 0);
    chk("t5_cpu_after", CPU_SLOT, 0);

    // 6: prefetch latency
    VBLANK = 0;
    mem[16'h1234] <= 16'h5A5A;
    wait_phase(0);
    strobe(1, 0, 0, 16'h1234);
    found = 0;
    n = 0;
    while (n < 200 && !found) begin
      @(posedge clk);
      #1;
      n++;
      found = (RDATA == 16'h5A5A);
    end
    chk("t6_rdata", RDATA, 16'h5A5A);
    chk("t6_latency", n, 55);
    chk("t6_busy_low", BUSY, 0);

    // Address and data strobes together: the write is dropped
    strobe(1, 0, 1, 16'h0001);
    chk("t7_overrun", OVERRUN, 1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
